axi4_chan_buf: RTL
==================

// Module: axi4_chan_buf
// PURPOSE
//  Generic buffered AXI4 channel stage for any A/W/B/R payload. It is a DEPTH-entry
//  valid/ready FIFO with no combinational path from m_ready to s_ready.
//  It provides synthesizable handshake and last-beat counters, carried into RTL from
//  the simulation-only counters on the channel interfaces. It sits between a channel
//  master and slave, e.g. the TL-RX to AXI fabric boundary.
// PARAMETERS
//  PAYLOAD_W  64  bits of packed channel payload (excluding valid/ready/last)
//  DEPTH      4   buffer entries; power of 2, >= 2
//  CNT_W      32  width of the handshake counters
// PORTS
//  aclk        in   1                  clock
//  areset_n    in   1                  reset, synchronous, active-low
//  s_valid     in   1                  upstream beat valid
//  s_ready     out  1                  upstream beat accepted when s_valid & s_ready
//  s_data      in   PAYLOAD_W          upstream payload
//  s_last      in   1                  upstream last beat of burst (tie 1 for A/B)
//  m_valid     out  1                  downstream beat valid
//  m_ready     in   1                  downstream ready
//  m_data      out  PAYLOAD_W          downstream payload (head entry)
//  m_last      out  1                  downstream last flag (head entry)
//  occupancy   out  $clog2(DEPTH)+1    entries currently stored
//  xfer_count  out  CNT_W              downstream handshakes since reset
//  last_count  out  CNT_W              downstream handshakes with m_last=1
//  err_stable  out  1                  sticky upstream stability violation (see CONFIG)
// BEHAVIOUR
//  Reset (areset_n=0 at posedge aclk): pointers=0, occupancy=0, m_valid=0, s_ready=1 after
//   the reset edge, xfer_count=0, last_count=0, err_stable=0. Storage array is not reset;
//   m_data/m_last are don't-care while m_valid=0.
//  Reset mid-operation discards all stored beats; no handshake is counted in the reset cycle.
//  Storage: flop array of {s_last,s_data}; wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits with
//   natural wrap. full = MSBs differ and LSBs equal; empty = pointers equal.
//  s_ready = !full, a function of registered state only; m_valid = !empty.
//  m_data/m_last = array[rd_ptr], a combinational read of registered storage.
//  push = s_valid & s_ready -> write at wr_ptr, wr_ptr+1.
//  pop  = m_valid & m_ready -> rd_ptr+1.
//  Latency: a beat pushed at edge N is visible on m_valid after edge N, so 1 cycle minimum.
//  Throughput: 1 beat/cycle sustained when m_ready=1 and DEPTH>=2.
//  Simultaneous push & pop: occupancy unchanged and both pointers advance.
//   When full, s_ready=0 even if m_ready=1 (no bypass).
//  When empty, the pop is impossible (m_valid=0) and a push makes occupancy 1.
//  Ordering is strict FIFO; payload and last are never modified.
//  m_valid is held and m_data/m_last are stable while m_ready=0 (AXI rule on the output side).
//  xfer_count increments on each pop; last_count increments on each pop with m_last=1.
//   Both saturate at all-ones (2^CNT_W-1) and do not wrap.
// CONFIGURATION
//  AXI4_CHAN_BUF_STABLE_CHK_EN defined:
//   A stall is s_valid=1 & s_ready=0 at edge t.
//   Violation: at edge t+1, s_valid=0, or s_data or s_last differ from their values at edge t.
//   A violation sets err_stable=1, which is sticky until reset. Adds PAYLOAD_W+2 capture flops.
//  Not defined: err_stable tied 0; no capture logic. All other behaviour is identical.
// TESTING
//  1. Reset, push 0xA1,0xA2 (s_last 0,1) with m_ready=1
//     -> m_data 0xA1 then 0xA2, one cycle after each push; xfer_count=2, last_count=1.
//  2. m_ready=0, push DEPTH=4 beats 0x10..0x13 -> s_ready=0 after the 4th, occupancy=4.
//     Hold s_valid on 0x14 for 3 cycles -> not accepted. Then m_ready=1 -> outputs
//     0x10..0x14 in order, no loss.
//  3. Occupancy 2, push+pop same cycle for 8 cycles -> occupancy stays 2,
//     ordering preserved, xfer_count +8.
//  4. CNT_W=4, 20 pops with m_last=1 -> xfer_count=15, last_count=15 (saturated).
//  5. Reset asserted with occupancy 3 -> next cycle m_valid=0, occupancy=0, counters 0,
//     s_ready=1. Later pushes are unaffected by the stale entries.
//  6. With the macro defined, stall then change s_data 0x55->0x66 while s_ready=0
//     -> err_stable=1 and it stays 1. Without the macro, the same stimulus leaves err_stable=0.

Source files
------------

// File: rtl/axi4_chan_buf.sv
// Buffered AXI4 channel stage: DEPTH-entry valid/ready FIFO with saturating handshake counters.
// Optional upstream stability checker enabled by defining AXI4_CHAN_BUF_STABLE_CHK_EN.
module axi4_chan_buf #(
  parameter int PAYLOAD_W = 64,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 32
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PAYLOAD_W-1:0]     s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [PAYLOAD_W-1:0]     m_data,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         xfer_count,
  output logic [CNT_W-1:0]         last_count,
  output logic                     err_stable
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PAYLOAD_W:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [PAYLOAD_W:0] head;

  // NOTE: s_ready comes only from the pointer registers, so m_ready never reaches it
  // combinationally; a full buffer refuses a beat even while it is being drained.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign s_ready   = !full;
  assign m_valid   = !empty;
  assign push      = s_valid && s_ready;
  assign pop       = m_valid && m_ready;
  assign occupancy = wr_ptr - rd_ptr;

  assign head   = mem[rd_ptr[AW-1:0]];
  assign m_data = head[PAYLOAD_W-1:0];
  assign m_last = head[PAYLOAD_W];

  // NOTE: the storage array has no reset; entries are only read once the pointers say
  // they were written, so clearing them would cost a reset net to every flop for nothing.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s_last, s_data};
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      xfer_count <= '0;
      last_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop && (xfer_count != '1))           xfer_count <= xfer_count + 1'b1;
      if (pop && m_last && (last_count != '1)) last_count <= last_count + 1'b1;
    end
  end

`ifdef AXI4_CHAN_BUF_STABLE_CHK_EN
  logic                 stall_q;
  logic [PAYLOAD_W-1:0] data_q;
  logic                 last_q;
  logic                 err_q;

  // A beat refused at one edge must reappear unchanged at the next edge.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= s_valid && !s_ready;
      if (stall_q && (!s_valid || (s_data != data_q) || (s_last != last_q))) err_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    data_q <= s_data;
    last_q <= s_last;
  end

  assign err_stable = err_q;
`else
  assign err_stable = 1'b0;
`endif

endmodule
